// File: rtl/cmos_byte_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | cmos_byte_capture: DVP RGB565 byte capture, frame skip, line-length repair, err count |
// | Optional macro CAM_TEST_PATTERN_EN adds test_mode.                         Rev 1.0   |
// +--------------------------------------------------------------------------------------+
module cmos_byte_capture #(
  parameter int          WAIT_FRAME   = 10,
  parameter logic [15:0] CMOS_H_PIXEL = 16'd640,
  parameter logic [15:0] CMOS_V_PIXEL = 16'd480
) (
  input  logic       cam_pclk,
  input  logic       rst_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
`ifdef CAM_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic       img_vsync,
  output logic       img_data_en,
  output logic [7:0] img_data,
  output logic       line_err,
  output logic [7:0] err_cnt
);

  localparam logic [16:0] LINE_BYTES = {CMOS_H_PIXEL, 1'b0};
  localparam logic [15:0] WAIT_CNT   = 16'(WAIT_FRAME);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAD    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        v1, v2, v3, h1, h2, h3;
  logic [7:0]  d1, d2;
  logic [15:0] frame_cnt, frame_cnt_nxt;
  logic [15:0] line_cnt, line_cnt_nxt, line_inc;
  logic [16:0] byte_cnt, byte_cnt_nxt, byte_inc;
  logic        ovf, ovf_nxt;
  logic        en_nxt, err_nxt;
  logic [7:0]  data_nxt, pix_cur, pix_new;
  logic        frame_start, v_rise, line_end, h_rise, in_frame;

  always_comb begin
    frame_start   = v3 & ~v2;
    v_rise        = v2 & ~v3;
    line_end      = h3 & ~h2;
    h_rise        = h2 & ~h3;
    line_inc      = line_cnt + 16'd1;
    byte_inc      = byte_cnt + 17'd1;
    in_frame      = line_cnt < CMOS_V_PIXEL;
`ifdef CAM_TEST_PATTERN_EN
    pix_cur       = test_mode ? (byte_cnt[7:0] ^ line_cnt[7:0]) : d2;
    pix_new       = test_mode ? line_inc[7:0] : d2;
`else
    pix_cur       = d2;
    pix_new       = d2;
`endif
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    line_cnt_nxt  = line_cnt;
    byte_cnt_nxt  = byte_cnt;
    ovf_nxt       = ovf;
    en_nxt        = 1'b0;
    data_nxt      = 8'h00;
    err_nxt       = 1'b0;

    case (state)
      ST_WAIT: begin
        if (frame_cnt == WAIT_CNT) begin
          state_nxt = ST_IDLE;
        end else if (v_rise) begin
          frame_cnt_nxt = frame_cnt + 16'd1;
        end
      end
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt    = ST_ACTIVE;
          line_cnt_nxt = 16'd0;
          byte_cnt_nxt = 17'd0;
          ovf_nxt      = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (line_end && byte_cnt != 17'd0) begin
          err_nxt = 1'b1;
          ovf_nxt = 1'b0;
          if (byte_cnt < LINE_BYTES) begin
            // first pad byte goes out right behind the last real byte
            en_nxt = 1'b1;
            if (byte_inc == LINE_BYTES) begin
              line_cnt_nxt = line_inc;
              byte_cnt_nxt = 17'd0;
            end else begin
              byte_cnt_nxt = byte_inc;
              state_nxt    = ST_PAD;
            end
          end else begin
            err_nxt      = ovf;
            line_cnt_nxt = line_inc;
            byte_cnt_nxt = 17'd0;
          end
        end else if (h2 && in_frame) begin
          if (byte_cnt < LINE_BYTES) begin
            en_nxt       = 1'b1;
            data_nxt     = pix_cur;
            byte_cnt_nxt = byte_inc;
          end else begin
            ovf_nxt = 1'b1;
          end
        end
      end
      ST_PAD: begin
        if (h_rise) begin
          // new line arrived before padding finished: close the old one, take this byte
          err_nxt      = 1'b1;
          line_cnt_nxt = line_inc;
          state_nxt    = ST_ACTIVE;
          if (line_inc < CMOS_V_PIXEL) begin
            en_nxt       = 1'b1;
            data_nxt     = pix_new;
            byte_cnt_nxt = 17'd1;
          end else begin
            byte_cnt_nxt = 17'd0;
          end
        end else begin
          en_nxt = 1'b1;
          if (byte_inc == LINE_BYTES) begin
            line_cnt_nxt = line_inc;
            byte_cnt_nxt = 17'd0;
            state_nxt    = ST_ACTIVE;
          end else begin
            byte_cnt_nxt = byte_inc;
          end
        end
      end
      default: state_nxt = ST_WAIT;
    endcase

    if (v_rise && (state == ST_ACTIVE || state == ST_PAD)) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      h1          <= 1'b0;
      h2          <= 1'b0;
      h3          <= 1'b0;
      d1          <= 8'h00;
      d2          <= 8'h00;
      state       <= ST_WAIT;
      frame_cnt   <= 16'd0;
      line_cnt    <= 16'd0;
      byte_cnt    <= 17'd0;
      ovf         <= 1'b0;
      img_vsync   <= 1'b0;
      img_data_en <= 1'b0;
      img_data    <= 8'h00;
      line_err    <= 1'b0;
      err_cnt     <= 8'h00;
    end else begin
      v1          <= cam_vsync;
      v2          <= v1;
      v3          <= v2;
      h1          <= cam_href;
      h2          <= h1;
      h3          <= h2;
      d1          <= cam_data;
      d2          <= d1;
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      line_cnt    <= line_cnt_nxt;
      byte_cnt    <= byte_cnt_nxt;
      ovf         <= ovf_nxt;
      img_vsync   <= (state != ST_WAIT) & v2;
      img_data_en <= en_nxt;
      img_data    <= data_nxt;
      line_err    <= err_nxt;
      if (err_nxt && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmos_byte_capture.sv
`default_nettype none
// tb_cmos_byte_capture: line-level expected-output model plus per-cycle compare.
module tb_cmos_byte_capture;

  localparam int P_WAIT = 2;
  localparam int P_V    = 2;
  localparam int LB     = 8;
  localparam int N      = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cam_vsync = 1'b0;
  logic       cam_href = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       img_vsync, img_data_en, line_err;
  logic [7:0] img_data, err_cnt;
`ifdef CAM_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  cmos_byte_capture #(
    .WAIT_FRAME  (P_WAIT),
    .CMOS_H_PIXEL(16'd4),
    .CMOS_V_PIXEL(16'd2)
  ) dut (
    .cam_pclk   (clk),
    .rst_n      (rst_n),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
`ifdef CAM_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .img_vsync  (img_vsync),
    .img_data_en(img_data_en),
    .img_data   (img_data),
    .line_err   (line_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected output per visible cycle index
  bit       exp_en [N];
  bit [7:0] exp_d  [N];
  bit       exp_er [N];
  bit       exp_vs [N];
  bit       vs_dc  [N];
  logic [7:0] seen_q[$];
  logic [7:0] m_errcnt = 8'h00;

  // model state at line/frame granularity
  int m_rises = 0;
  bit m_out   = 1'b0;
  int m_line  = 0;
  bit m_abort = 1'b0;
  bit m_tp    = 1'b0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (cyc < N) begin
      if (!rst_n) m_errcnt = 8'h00;
      else if (exp_er[cyc] && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
      chk("img_data_en", {7'd0, img_data_en}, {7'd0, exp_en[cyc]});
      chk("img_data", img_data, exp_d[cyc]);
      chk("line_err", {7'd0, line_err}, {7'd0, exp_er[cyc]});
      chk("err_cnt", err_cnt, m_errcnt);
      if (!vs_dc[cyc]) chk("img_vsync", {7'd0, img_vsync}, {7'd0, exp_vs[cyc]});
      if (img_data_en === 1'b1) seen_q.push_back(img_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void set_byte(input int idx, input logic [7:0] d);
    if (idx < N) begin
      exp_en[idx] = 1'b1;
      exp_d[idx]  = d;
    end
  endfunction

  function automatic void set_err(input int idx);
    if (idx < N) exp_er[idx] = 1'b1;
  endfunction

  // Drive one href line of n bytes base,base+1,... followed by gap idle cycles.
  task automatic send_line(input int n, input logic [7:0] base, input int gap);
    int k0;
    int m;
    int pads;
    logic [7:0] v;
    k0 = cyc;
    if (m_abort) begin
      set_err(k0 + 3);
      m_abort = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      v = base + 8'(i);
      cam_href = 1'b1;
      cam_data = v;
      if (m_out && m_line < P_V && i < LB)
        set_byte(cyc + 3, m_tp ? (8'(i) ^ 8'(m_line)) : v);
      tick();
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    if (m_out && m_line < P_V) begin
      m = (n < LB) ? n : LB;
      if (n > LB) set_err(k0 + n + 3);
      if (m < LB) begin
        set_err(k0 + n + 3);
        pads = LB - m;
        if (pads > gap) begin
          pads = gap;
          m_abort = 1'b1;
        end
        for (int j = 0; j < pads; j++) set_byte(k0 + n + 3 + j, 8'h00);
      end
      m_line++;
    end
    repeat (gap) tick();
  endtask

  task automatic vsync_pulse(input int w);
    int k;
    k = cyc;
    m_rises++;
    cam_vsync = 1'b1;
    if (m_rises > P_WAIT) begin
      for (int j = 0; j < w; j++) if (k + 3 + j < N) exp_vs[k + 3 + j] = 1'b1;
    end else if (m_rises == P_WAIT) begin
      for (int j = 1; j <= w + 4; j++) if (k + j < N) vs_dc[k + j] = 1'b1;
    end
    repeat (w) tick();
    cam_vsync = 1'b0;
    m_out   = (m_rises >= P_WAIT);
    m_line  = 0;
    m_abort = 1'b0;
    repeat (3) tick();
  endtask

  task automatic three_frames();
    for (int f = 0; f < 3; f++) begin
      send_line(8, 8'h01, 4);
      send_line(8, 8'h01, 4);
      vsync_pulse(4);
      if (f == 1) chk("discard_frames_1_2", 8'(seen_q.size()), 8'd0);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_err_cnt", err_cnt, 8'h00);
    chk("reset_data", img_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // power-up: two frames discarded, third in full
    seen_q.delete();
    three_frames();
    chk("powerup_count", 8'(seen_q.size()), 8'd16);

    // nominal frame
    seen_q.delete();
    send_line(8, 8'h01, 4);
    send_line(8, 8'h01, 4);
    vsync_pulse(4);
    chk("nominal_count", 8'(seen_q.size()), 8'd16);
    for (int i = 0; i < 16 && i < seen_q.size(); i++)
      chk("nominal_byte", seen_q[i], 8'((i % 8) + 1));
    chk("nominal_err_cnt", err_cnt, 8'h00);

`ifdef CAM_TEST_PATTERN_EN
    seen_q.delete();
    test_mode = 1'b1;
    m_tp = 1'b1;
    send_line(8, 8'h55, 4);
    send_line(8, 8'h55, 4);
    vsync_pulse(4);
    test_mode = 1'b0;
    m_tp = 1'b0;
    chk("pattern_l1_b3", (seen_q.size() > 11) ? seen_q[11] : 8'hXX, 8'h02);
`endif

    // short line: 5 data then 3 pad
    seen_q.delete();
    send_line(5, 8'h01, 10);
    send_line(8, 8'h01, 4);
    vsync_pulse(4);
    chk("short_count", 8'(seen_q.size()), 8'd16);
    for (int i = 0; i < 8 && i < seen_q.size(); i++)
      chk("short_byte", seen_q[i], (i < 5) ? 8'(i + 1) : 8'h00);
    chk("short_err_cnt", err_cnt, 8'd1);

    // overlong line truncated, third line dropped
    seen_q.delete();
    send_line(11, 8'h10, 4);
    send_line(8, 8'h20, 4);
    send_line(8, 8'h30, 4);
    vsync_pulse(4);
    chk("overlong_count", 8'(seen_q.size()), 8'd16);
    chk("overlong_last", (seen_q.size() > 7) ? seen_q[7] : 8'hXX, 8'h17);
    chk("overlong_err_cnt", err_cnt, 8'd2);

    // pad abort
    seen_q.delete();
    send_line(2, 8'h40, 2);
    send_line(8, 8'h50, 4);
    vsync_pulse(4);
    chk("abort_count", 8'(seen_q.size()), 8'd12);
    chk("abort_pad", (seen_q.size() > 3) ? seen_q[3] : 8'hXX, 8'h00);
    chk("abort_next", (seen_q.size() > 4) ? seen_q[4] : 8'hXX, 8'h50);
    chk("abort_err_cnt", err_cnt, 8'd4);

    // saturation: 300 bad lines
    for (int f = 0; f < 150; f++) begin
      send_line(1, 8'hA0, 1);
      send_line(1, 8'hA1, 10);
      vsync_pulse(4);
    end
    chk("sat_err_cnt", err_cnt, 8'hFF);

    // reset in the middle of a line, then re-skip two frames
    for (int i = 0; i < 3; i++) begin
      cam_href = 1'b1;
      cam_data = 8'hC0 + 8'(i);
      tick();
    end
    rst_n = 1'b0;
    cam_href = 1'b0;
    cam_data = 8'h00;
    m_rises = 0;
    m_out = 1'b0;
    m_line = 0;
    m_abort = 1'b0;
    repeat (2) tick();
    chk("midreset_err_cnt", err_cnt, 8'h00);
    chk("midreset_en", {7'd0, img_data_en}, 8'd0);
    rst_n = 1'b1;
    tick();
    seen_q.delete();
    three_frames();
    chk("rearm_count", 8'(seen_q.size()), 8'd16);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmos_byte_capture.md
CMOS_BYTE_CAPTURE -- requirements
Module: cmos_byte_capture

Interface
REQ-001 The block SHALL declare parameter WAIT_FRAME, default 10, as the number of camera frames discarded after reset.
REQ-002 The block SHALL declare parameter CMOS_H_PIXEL, default 16'd640, as the pixels per line; bytes per line are 2*CMOS_H_PIXEL.
REQ-003 The block SHALL declare parameter CMOS_V_PIXEL, default 16'd480, as the lines per frame.
REQ-004 The block SHALL have port cam_pclk, input, 1 bit: pixel clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port cam_vsync, input, 1 bit: DVP frame sync, high between frames.
REQ-007 The block SHALL have port cam_href, input, 1 bit: DVP line valid.
REQ-008 The block SHALL have port cam_data, input, 8 bits: DVP byte, two bytes per RGB565 pixel.
REQ-009 The block SHALL have port img_vsync, output, 1 bit: frame sync toward the packetizer.
REQ-010 The block SHALL have port img_data_en, output, 1 bit: byte valid.
REQ-011 The block SHALL have port img_data, output, 8 bits: byte payload.
REQ-012 The block SHALL have port line_err, output, 1 bit: one-cycle pulse when a line length is wrong.
REQ-013 The block SHALL have port err_cnt, output, 8 bits: saturating count of line errors.

Function
REQ-014 The block SHALL register cam_vsync, cam_href and cam_data through two stages; all decisions use stage-2 values (v2, h2, d2).
REQ-015 The block SHALL take the frame start as the falling edge of v2 and the line end as the falling edge of h2.
REQ-016 The block SHALL implement a state machine with states WAIT, IDLE, ACTIVE and PAD.
REQ-017 In WAIT, the block SHALL count rising edges of v2 and go to IDLE when the count reaches WAIT_FRAME; the counter then holds.
REQ-018 In IDLE, the block SHALL go to ACTIVE on the frame start and clear line_cnt and byte_cnt.
REQ-019 In ACTIVE, for each cycle with h2=1, line_cnt<CMOS_V_PIXEL and byte_cnt<2*CMOS_H_PIXEL, the block SHALL assert img_data_en=1 and img_data=d2, and increment byte_cnt.
- Cam_data to img_data latency is 3 cycles (2 sync stages + 1 output register).
REQ-020 The block SHALL NOT output bytes beyond 2*CMOS_H_PIXEL in a line (overlong lines are truncated); such a line SHALL pulse line_err.
REQ-021 On line end in ACTIVE with 0<byte_cnt<2*CMOS_H_PIXEL, the block SHALL go to PAD.
- PAD emits img_data_en=1, img_data=8'h00 each cycle until byte_cnt reaches 2*CMOS_H_PIXEL, then returns to ACTIVE.
- Such a short line SHALL pulse line_err.
REQ-022 If h2 rises while in PAD, the block SHALL abort padding and return to ACTIVE, counting the new line.
- This is one extra line_err pulse and err_cnt increment for the aborted line.
REQ-023 At each line end with byte_cnt>0, the block SHALL increment line_cnt and clear byte_cnt; lines with line_cnt>=CMOS_V_PIXEL produce no output.
REQ-024 The block SHALL return to IDLE from ACTIVE or PAD on a rising edge of v2; on a simultaneous line end, the line end is processed in the same cycle.
REQ-025 The block SHALL drive img_vsync = v2 delayed 1 cycle while in IDLE, ACTIVE or PAD, and hold it 0 in WAIT.
REQ-026 The block SHALL increment err_cnt on each line_err pulse and saturate it at 8'hFF.
REQ-027 In every cycle with no output byte, the block SHALL drive img_data_en=0 and img_data=8'h00.

Reset
REQ-028 rst_n low SHALL asynchronously force the following reset values:
- state=WAIT, all counters 0, sync stages 0.
- img_vsync=0, img_data_en=0, img_data=8'h00, line_err=0, err_cnt=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, WAIT_FRAME frames are discarded again.

Configuration
REQ-030 With macro CAM_TEST_PATTERN_EN defined, the block SHALL add input test_mode (1 bit).
- When test_mode=1, img_data SHALL be byte_cnt[7:0] XOR line_cnt[7:0] in place of d2; timing, padding and errors are unchanged.
REQ-031 Without CAM_TEST_PATTERN_EN, the block SHALL have no test_mode port and SHALL always forward d2.

Verification
REQ-032 Power-up scenario: WAIT_FRAME=2, three frames -> no img_data_en and img_vsync=0 for frames 1-2; frame 3 is output in full.
REQ-033 Nominal scenario: H=4, V=2, lines of 8 bytes 0x01..0x08 -> 16 enables, data 01..08 per line, each 3 cycles after input, line_err never.
REQ-034 Short-line scenario: H=4, a 5-byte line -> 5 data bytes then 3 bytes of 00 contiguous after href falls, line_err pulse, err_cnt=1.
REQ-035 Overlong and extra-line scenario: H=4, an 11-byte line -> 8 bytes output, line_err=1; with V=2, a third line produces no output.
REQ-036 Pad-abort and saturation scenario: href rises during PAD -> padding stops, err_cnt increments; 300 bad lines -> err_cnt=8'hFF.
REQ-037 Test-pattern scenario (CAM_TEST_PATTERN_EN, test_mode=1): line 1, byte 3 -> img_data=8'h02.
